run_detect_ctrl: RTL and testbench

RUN_DETECT_CTRL -- requirements
Module: run_detect_ctrl

---
 rtl/run_ctrl_pkg.sv | 25 ++
 rtl/run_len_counter.sv | 52 +++++
 rtl/run_detect_ctrl.sv | 121 ++++++++++++
 tb/tb_run_detect_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the serial run detector: controller states,
// mode encodings and the configuration loaded on reset.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] MODE_ONES  = 2'b00;
  localparam logic [1:0] MODE_ZEROS = 2'b01;
  localparam logic [1:0] MODE_BOTH  = 2'b10;

  localparam int         DEF_LEN   = 3;
  localparam logic [1:0] DEF_MODE  = MODE_BOTH;
  localparam int         DEF_LIMIT = 0;
  localparam int         MIN_LEN   = 2;

  // Mode 1x accepts either polarity; otherwise bit 0 selects runs of zeros.
  function automatic logic bit_matches(input logic [1:0] mode, input logic b);
    return mode[1] | (mode[0] ? ~b : b);
  endfunction

endpackage

// File: rtl/run_len_counter.sv
// Tracks the previous sample bit and the saturating length of the current run.
// run_len_nxt_o is the length the run will have if the present bit is sampled.
module run_len_counter #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             smp_en_i,
  input  logic             bit_i,
  output logic [LEN_W-1:0] run_len_nxt_o
);

  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  logic             last_bit_q, last_bit_d;
  logic [LEN_W-1:0] run_len_q, run_len_d;

  // A zero length marks empty history, so the first sample always starts at 1.
  always_comb begin
    if ((run_len_q == '0) || (bit_i != last_bit_q)) begin
      run_len_nxt_o = LEN_W'(1);
    end else if (run_len_q == LEN_MAX) begin
      run_len_nxt_o = LEN_MAX;
    end else begin
      run_len_nxt_o = run_len_q + LEN_W'(1);
    end
  end

  always_comb begin
    run_len_d  = run_len_q;
    last_bit_d = last_bit_q;
    if (clr_i) begin
      run_len_d  = '0;
      last_bit_d = 1'b0;
    end else if (smp_en_i) begin
      run_len_d  = run_len_nxt_o;
      last_bit_d = bit_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_len_q  <= '0;
      last_bit_q <= 1'b0;
    end else begin
      run_len_q  <= run_len_d;
      last_bit_q <= last_bit_d;
    end
  end

endmodule

// File: rtl/run_detect_ctrl.sv
// Serial run-length detector: counts samples that extend a run of the selected
// polarity to at least the configured length, stopping after an optional limit.
module run_detect_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic             in,
  output logic             hit,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_count
);

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l < LEN_W'(MIN_LEN)) ? LEN_W'(MIN_LEN) : l;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic             hit_q, hit_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [LEN_W-1:0] run_len_nxt;
  logic             smp_en, clr, qualify;

  // Abort suppresses the sample it coincides with, so the run history is frozen too.
  assign smp_en  = (state_q == ST_RUN) && in_valid && !abort;
  assign clr     = (state_q == ST_IDLE) && start;
  assign qualify = smp_en && (run_len_nxt >= len_q) && bit_matches(mode_q, in);
  assign cnt_inc = sat_inc(cnt_q);

  run_len_counter #(
    .LEN_W (LEN_W)
  ) u_run_len (
    .clk           (clk),
    .reset         (reset),
    .clr_i         (clr),
    .smp_en_i      (smp_en),
    .bit_i         (in),
    .run_len_nxt_o (run_len_nxt)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    mode_d  = mode_q;
    limit_d = limit_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    done_d  = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          len_d   = clamp_len(cfg_len);
          mode_d  = cfg_mode;
          limit_d = cfg_limit;
        end
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (qualify) begin
          hit_d = 1'b1;
          cnt_d = cnt_inc;
          if ((limit_q != '0) && (cnt_inc == limit_q)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      len_q   <= LEN_W'(DEF_LEN);
      mode_q  <= DEF_MODE;
      limit_q <= CNT_W'(DEF_LIMIT);
      hit_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      limit_q <= limit_d;
      hit_q   <= hit_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cfg_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN);
  assign hit       = hit_q;
  assign done      = done_q;
  assign hit_count = cnt_q;

endmodule

// File: tb/tb_run_detect_ctrl.sv
// Directed bench for run_detect_ctrl: a table of single-cycle vectors with
// hand-computed outputs, plus sequences for saturation and asynchronous reset.
module tb_run_detect_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_len = '0;
  logic [1:0] cfg_mode = '0;
  logic [7:0] cfg_limit = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic       din = 1'b0;
  logic       hit, busy, done;
  logic [7:0] hit_count;

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  run_detect_ctrl #(.LEN_W(4), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_len   (cfg_len),
    .cfg_mode  (cfg_mode),
    .cfg_limit (cfg_limit),
    .start     (start),
    .abort     (abort),
    .in_valid  (in_valid),
    .in        (din),
    .hit       (hit),
    .busy      (busy),
    .done      (done),
    .hit_count (hit_count)
  );

  typedef struct {
    logic       cv;
    logic [3:0] len;
    logic [1:0] mode;
    logic [7:0] lim;
    logic       st, ab, iv, d;
    logic       hit, busy, done, rdy;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic cv, input logic [3:0] len, input logic [1:0] mode,
                             input logic [7:0] lim, input logic st, input logic ab,
                             input logic iv, input logic d, input logic h, input logic b,
                             input logic dn, input logic r, input logic [7:0] c);
    vec_t x;
    x.cv = cv; x.len = len; x.mode = mode; x.lim = lim;
    x.st = st; x.ab = ab; x.iv = iv; x.d = d;
    x.hit = h; x.busy = b; x.done = dn; x.rdy = r; x.cnt = c;
    return x;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic cv, input logic [3:0] len, input logic [1:0] mode,
                       input logic [7:0] lim, input logic st, input logic ab,
                       input logic iv, input logic d);
    cfg_valid = cv; cfg_len = len; cfg_mode = mode; cfg_limit = lim;
    start = st; abort = ab; in_valid = iv; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic h, input logic b, input logic dn,
                            input logic r, input logic [7:0] c);
    check({tag, ".hit"},   int'(hit),       int'(h));
    check({tag, ".busy"},  int'(busy),      int'(b));
    check({tag, ".done"},  int'(done),      int'(dn));
    check({tag, ".ready"}, int'(cfg_ready), int'(r));
    check({tag, ".count"}, int'(hit_count), int'(c));
  endtask

  initial begin
    // Default config: 1,1,1,1,0,0,0 hits on samples 3,4,7.
    tbl.push_back(v(0,0,0,0, 1,0,0,0, 0,1,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,1,1, 0,1,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,1,1, 0,1,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,1,1, 1,1,0,0,1));
    tbl.push_back(v(0,0,0,0, 0,0,1,1, 1,1,0,0,2));
    tbl.push_back(v(0,0,0,0, 0,0,1,0, 0,1,0,0,2));
    tbl.push_back(v(0,0,0,0, 0,0,1,0, 0,1,0,0,2));
    tbl.push_back(v(0,0,0,0, 0,0,1,0, 1,1,0,0,3));
    tbl.push_back(v(0,0,0,0, 0,1,0,0, 0,0,0,1,3));
    tbl.push_back(v(0,0,0,0, 0,0,1,1, 0,0,0,1,3));
    // len 4, ones only, with gaps; config and start offered mid-run are ignored.
    tbl.push_back(v(1,4,2'b00,0, 1,0,0,0, 0,1,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,1,1, 0,1,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,0,0, 0,1,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,1,1, 0,1,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,1,1, 0,1,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,0,0, 0,1,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,1,1, 1,1,0,0,1));
    tbl.push_back(v(0,0,0,0, 0,0,0,0, 0,1,0,0,1));
    tbl.push_back(v(0,0,0,0, 0,0,1,1, 1,1,0,0,2));
    tbl.push_back(v(0,0,0,0, 0,0,1,1, 1,1,0,0,3));
    tbl.push_back(v(0,0,0,0, 0,0,1,0, 0,1,0,0,3));
    tbl.push_back(v(1,2,2'b10,0, 0,0,1,0, 0,1,0,0,3));
    tbl.push_back(v(0,0,0,0, 1,0,1,0, 0,1,0,0,3));
    tbl.push_back(v(0,0,0,0, 0,0,1,0, 0,1,0,0,3));
    tbl.push_back(v(0,0,0,0, 0,0,1,0, 0,1,0,0,3));
    tbl.push_back(v(0,0,0,0, 0,0,1,1, 0,1,0,0,3));
    tbl.push_back(v(0,0,0,0, 0,1,0,0, 0,0,0,1,3));
    // limit 2, zeros: hits on 3,4, done next cycle; start/abort/sample in DONE ignored.
    tbl.push_back(v(1,3,2'b01,2, 1,0,0,0, 0,1,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,1,0, 0,1,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,1,0, 0,1,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,1,0, 1,1,0,0,1));
    tbl.push_back(v(0,0,0,0, 0,0,1,0, 1,0,0,0,2));
    tbl.push_back(v(0,0,0,0, 1,1,1,0, 0,0,1,1,2));
    tbl.push_back(v(0,0,0,0, 0,0,1,0, 0,0,0,1,2));
    // Abort coincident with the qualifying third 1.
    tbl.push_back(v(1,3,2'b10,0, 1,0,0,0, 0,1,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,1,1, 0,1,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,1,1, 0,1,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,1,1,1, 0,0,0,1,0));
    tbl.push_back(v(0,0,0,0, 0,0,0,0, 0,0,0,1,0));
    // len 1 clamps to 2: 1,0,0 hits only on sample 3.
    tbl.push_back(v(1,1,2'b10,0, 1,0,0,0, 0,1,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,1,1, 0,1,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,1,0, 0,1,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,1,0, 1,1,0,0,1));
    tbl.push_back(v(0,0,0,0, 0,1,0,0, 0,0,0,1,1));
    // len 0 clamps to 2 as well.
    tbl.push_back(v(1,0,2'b00,0, 1,0,0,0, 0,1,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,1,1, 0,1,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,1,1, 1,1,0,0,1));
    tbl.push_back(v(0,0,0,0, 0,1,0,0, 0,0,0,1,1));

    // Reset state, observed both during and after reset.
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset_held", 0, 0, 0, 1, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_outs("reset_rel", 0, 0, 0, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].cv, tbl[i].len, tbl[i].mode, tbl[i].lim,
            tbl[i].st, tbl[i].ab, tbl[i].iv, tbl[i].d);
      check_outs($sformatf("row%0d", i), tbl[i].hit, tbl[i].busy, tbl[i].done,
                 tbl[i].rdy, tbl[i].cnt);
    end

    // Run length saturates at 15 instead of wrapping: hits continue past sample 15.
    drive(1, 4'd15, 2'b00, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 1);
      check($sformatf("rl_sat.s%0d", k), int'(hit), (k >= 15) ? 1 : 0);
    end
    check("rl_sat.count", int'(hit_count), 6);
    drive(0, 0, 0, 0, 0, 1, 0, 0);

    // Hit count saturates at 255 with an unbounded limit.
    drive(1, 4'd2, 2'b10, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 300; k++) drive(0, 0, 0, 0, 0, 0, 1, 1);
    check("cnt_sat.count", int'(hit_count), 255);
    check("cnt_sat.hit", int'(hit), 1);
    check("cnt_sat.busy", int'(busy), 1);
    drive(0, 0, 0, 0, 0, 1, 0, 0);

    // Asynchronous reset mid-run with hit_count 5, then defaults are back in force.
    drive(1, 4'd2, 2'b00, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 6; k++) drive(0, 0, 0, 0, 0, 0, 1, 1);
    check_outs("pre_reset", 1, 1, 0, 0, 5);
    #3;
    reset = 1'b1;
    #1;
    check_outs("async_reset", 0, 0, 0, 1, 0);
    cfg_valid = 0; start = 0; abort = 0; in_valid = 0; din = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    check("post_reset.s1", int'(hit), 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    check("post_reset.s2", int'(hit), 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    check_outs("post_reset.s3", 1, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
